// File: rtl/picc_rx_decoder.sv
// PICC-to-PCD receive decoder: integrates sample magnitude per half-bit, Manchester-decodes
// the sliced levels, and emits LSB-first bytes with odd-parity and coding status on AXI-Stream.
module picc_rx_decoder #(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned HALF_BIT_SAMPLES       = 64,
  parameter logic [31:0] SAMPLE_THRESHOLD       = 32'd1000,
  parameter logic [39:0] ENERGY_THRESHOLD       = 40'd32000
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic [15:0]                           frame_count_out,
  output logic                                  overflow_out
);

  localparam int unsigned SW    = C_S00_AXIS_TDATA_WIDTH;
  localparam int unsigned MW    = C_M00_AXIS_TDATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(HALF_BIT_SAMPLES);
  localparam int unsigned ACC_W = SW + CNT_W;
  localparam int unsigned CMP_W = (ACC_W > 40) ? ACC_W : 40;
  localparam int unsigned THR_W = (SW > 32) ? SW : 32;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(HALF_BIT_SAMPLES - 1);
  localparam logic [SW-1:0]    SMIN        = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_SOF, ST_DATA} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] samp_cnt_q;
  logic [ACC_W-1:0] acc_q, acc_sat;
  logic [ACC_W:0]   acc_sum;
  logic             half_q, first_q;
  logic [7:0]       bits_q, pend_q;
  logic [3:0]       bit_cnt_q;
  logic             pend_vld_q, pend_perr_q;
  logic             out_vld_q, out_last_q, ovf_q;
  logic [MW-1:0]    out_data_q, emit_word;
  logic [15:0]      fcnt_q;
  logic [SW-1:0]    mag;
  logic             beat, trigger, win_done, pair_done, level, perr_calc;
  logic             emit, emit_last, shift_en, pend_load, pend_clr, clr_bits;
  logic             unused_inputs;

  assign unused_inputs = ^{s00_axis_tlast, s00_axis_tstrb};

  function automatic logic [MW-1:0] mk_word(input logic [7:0] d, input logic perr,
                                            input logic cerr, input logic [3:0] cnt);
    logic [MW-1:0] w;
    w        = '0;
    w[7:0]   = d;
    w[8]     = perr;
    w[9]     = cerr;
    w[13:10] = cnt;
    return w;
  endfunction

  assign s00_axis_tready = s00_axis_aresetn;
  assign beat            = s00_axis_tvalid && s00_axis_tready;

  always_comb begin
    mag = s00_axis_tdata;
    if (s00_axis_tdata[SW-1]) mag = (s00_axis_tdata == SMIN) ? ~SMIN : -s00_axis_tdata;
  end

  assign acc_sum   = {1'b0, acc_q} + {{(CNT_W+1){1'b0}}, mag};
  assign acc_sat   = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  assign level     = CMP_W'(acc_sat) > CMP_W'(ENERGY_THRESHOLD);
  assign trigger   = beat && (THR_W'(mag) > THR_W'(SAMPLE_THRESHOLD));
  assign win_done  = beat && (state_q != ST_IDLE) && (samp_cnt_q == LAST_SAMPLE);
  assign pair_done = win_done && half_q;
  assign perr_calc = ~^{bits_q, first_q};

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) state_q <= ST_IDLE;
    else                   state_q <= state_d;
  end

  // Bit value is the first half-bit level; on equal halves, first_q==1 marks a coding error.
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_word = '0;
    emit_last = 1'b0;
    shift_en  = 1'b0;
    pend_load = 1'b0;
    pend_clr  = 1'b0;
    clr_bits  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (trigger) state_d = ST_SOF;
      ST_SOF: if (pair_done) begin
        if (first_q && !level) begin
          state_d  = ST_DATA;
          clr_bits = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: if (pair_done) begin
        if (first_q != level) begin
          if (pend_vld_q) begin
            emit      = 1'b1;
            emit_word = mk_word(pend_q, pend_perr_q, 1'b0, 4'd8);
            pend_clr  = 1'b1;
          end
          if (bit_cnt_q == 4'd8) begin
            pend_load = 1'b1;
            clr_bits  = 1'b1;
          end else begin
            shift_en = 1'b1;
          end
        end else begin
          state_d   = ST_IDLE;
          pend_clr  = 1'b1;
          clr_bits  = 1'b1;
          emit_last = 1'b1;
          if (pend_vld_q) begin
            emit      = 1'b1;
            emit_word = mk_word(pend_q, pend_perr_q, first_q, 4'd8);
          end else if (bit_cnt_q != 4'd0) begin
            emit      = 1'b1;
            emit_word = mk_word(bits_q, 1'b0, first_q, bit_cnt_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      samp_cnt_q  <= '0;
      acc_q       <= '0;
      half_q      <= 1'b0;
      first_q     <= 1'b0;
      bits_q      <= '0;
      bit_cnt_q   <= '0;
      pend_q      <= '0;
      pend_perr_q <= 1'b0;
      pend_vld_q  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        half_q     <= 1'b0;
        acc_q      <= trigger ? {{CNT_W{1'b0}}, mag} : '0;
        samp_cnt_q <= trigger ? CNT_W'(1) : '0;
      end else if (beat) begin
        if (win_done) begin
          acc_q      <= '0;
          samp_cnt_q <= '0;
          half_q     <= ~half_q;
          if (!half_q) first_q <= level;
        end else begin
          acc_q      <= acc_sat;
          samp_cnt_q <= samp_cnt_q + 1'b1;
        end
      end
      if (clr_bits) begin
        bits_q    <= '0;
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bits_q[bit_cnt_q[2:0]] <= first_q;
        bit_cnt_q              <= bit_cnt_q + 4'd1;
      end
      if (pend_load) begin
        pend_q      <= bits_q;
        pend_perr_q <= perr_calc;
        pend_vld_q  <= 1'b1;
      end else if (pend_clr) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      ovf_q      <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      if (out_vld_q && m00_axis_tready) out_vld_q <= 1'b0;
      if (emit) begin
        if (!out_vld_q || m00_axis_tready) begin
          out_vld_q  <= 1'b1;
          out_data_q <= emit_word;
          out_last_q <= emit_last;
        end else begin
          ovf_q <= 1'b1;
        end
      end
      // A dropped end-of-frame word still closes the frame.
      if ((out_vld_q && m00_axis_tready && out_last_q) ||
          (emit && emit_last && out_vld_q && !m00_axis_tready))
        fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign m00_axis_tvalid = out_vld_q;
  assign m00_axis_tdata  = out_data_q;
  assign m00_axis_tlast  = out_last_q;
  assign m00_axis_tstrb  = {(MW/8){out_vld_q}};
  assign frame_count_out = fcnt_q;
  assign overflow_out    = ovf_q;

endmodule

// File: tb/tb_picc_rx_decoder.sv
// Self-checking bench for picc_rx_decoder: directed frame table, hand-written corner
// sequences, and random frames scored against a byte-level frame model.
`timescale 1ns/1ps
module tb_picc_rx_decoder;

  logic        clk;
  logic        aresetn;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        m_tready, m_tvalid, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic [15:0] fcnt;
  logic        ovf;

  int checks;
  int errors;
  int exp_fcnt;
  int rdy_mode;
  logic [32:0] got [$];

  typedef struct {
    string       name;
    logic [63:0] bits;
    int          nbits;
    bit          cerr;
    int          nw;
    logic [32:0] exp [4];
  } vec_t;

  vec_t dir [9];

  picc_rx_decoder #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .HALF_BIT_SAMPLES(4),
    .SAMPLE_THRESHOLD(32'd1000),
    .ENERGY_THRESHOLD(40'd3000)
  ) dut (
    .s00_axis_aclk(clk),
    .s00_axis_aresetn(aresetn),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tready(s_tready),
    .s00_axis_tdata(s_tdata),
    .s00_axis_tlast(s_tlast),
    .s00_axis_tstrb(s_tstrb),
    .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tlast(m_tlast),
    .m00_axis_tdata(m_tdata),
    .m00_axis_tstrb(m_tstrb),
    .frame_count_out(fcnt),
    .overflow_out(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Downstream ready: 0 = always ready, 1 = random stalls of at most two cycles, 2 = stalled.
  initial begin
    int lowrun;
    lowrun   = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: begin
          if (lowrun >= 2 || $urandom_range(0, 3) != 0) begin
            m_tready = 1'b1;
            lowrun   = 0;
          end else begin
            m_tready = 1'b0;
            lowrun++;
          end
        end
        default: m_tready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input logic [31:0] d);
    while ($urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      s_tdata  = $urandom;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = 1'($urandom);
    s_tstrb  = 4'($urandom);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_beat(32'd0);
  endtask

  task automatic send_half(input bit lvl);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      if (lvl) begin
        m = $urandom_range(1500, 3000);
        if ($urandom_range(0, 15) == 0) m = 32'h8000_0000;
      end else begin
        m = $urandom_range(0, 200);
      end
      if ($urandom_range(0, 1) == 1) m = ~m + 32'd1;
      drive_beat(m);
    end
  endtask

  task automatic send_frame(input vec_t v);
    send_half(1'b1);
    send_half(1'b0);
    for (int i = 0; i < v.nbits; i++) begin
      send_half(v.bits[i]);
      send_half(!v.bits[i]);
    end
    send_half(v.cerr);
    send_half(v.cerr);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_tvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 64'(m_tvalid), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    send_frame(v);
    idle(6);
    drain();
    check({v.name, "_nwords"}, 64'(got.size()), 64'(v.nw));
    for (int i = 0; i < v.nw && i < got.size(); i++)
      check($sformatf("%s_word%0d", v.name, i), 64'(got[i]), 64'(v.exp[i]));
    if (v.nw > 0) exp_fcnt++;
    check({v.name, "_frame_count"}, 64'(fcnt), 64'(exp_fcnt[15:0]));
    check({v.name, "_overflow"}, 64'(ovf), 64'd0);
    got.delete();
  endtask

  function automatic vec_t mkv(input string n, input logic [63:0] b, input int nb, input bit ce,
                               input int nw, input logic [32:0] e0, input logic [32:0] e1,
                               input logic [32:0] e2);
    vec_t v;
    v.name   = n;
    v.bits   = b;
    v.nbits  = nb;
    v.cerr   = ce;
    v.nw     = nw;
    v.exp[0] = e0;
    v.exp[1] = e1;
    v.exp[2] = e2;
    v.exp[3] = '0;
    return v;
  endfunction

  // Frame model: whole bytes with odd parity, an optional partial tail, then EOF or a
  // coding error; the final emitted word carries tlast, and coding_err on a coding-error end.
  task automatic rand_frame(input int k, output vec_t v);
    int nbytes, p, pos;
    logic [7:0] b, pb;
    bit par, perr;
    int unsigned w;
    nbytes = $urandom_range(0, 3);
    p      = $urandom_range(0, 7);
    v.name = $sformatf("rand%0d", k);
    v.cerr = ($urandom_range(0, 3) == 0);
    v.bits = '0;
    v.nw   = 0;
    for (int i = 0; i < 4; i++) v.exp[i] = '0;
    pos = 0;
    for (int i = 0; i < nbytes; i++) begin
      b   = 8'($urandom);
      par = ($countones(b) % 2 == 0);
      if ($urandom_range(0, 4) == 0) par = !par;
      perr = (($countones(b) + int'(par)) % 2 == 0);
      v.bits = v.bits | (64'({par, b}) << pos);
      pos += 9;
      w = (32'd8 << 10) | (32'(perr) << 8) | 32'(b);
      v.exp[v.nw] = {1'b0, w};
      v.nw++;
    end
    if (p > 0) begin
      pb = 8'($urandom_range(0, (1 << p) - 1));
      v.bits = v.bits | (64'(pb) << pos);
      pos += p;
      w = (32'(p) << 10) | 32'(pb);
      v.exp[v.nw] = {1'b0, w};
      v.nw++;
    end
    v.nbits = pos;
    if (v.nw > 0) begin
      v.exp[v.nw-1][32] = 1'b1;
      if (v.cerr) v.exp[v.nw-1][9] = 1'b1;
    end
  endtask

  initial begin
    vec_t v;
    checks   = 0;
    errors   = 0;
    exp_fcnt = 0;
    rdy_mode = 0;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tstrb  = '0;

    dir[0] = mkv("byte35", 64'h135, 9, 1'b0, 1, 33'h1_0000_2035, '0, '0);
    dir[1] = mkv("three_bytes", 64'h124 | (64'h190 << 9) | (64'h067 << 18), 27, 1'b0, 3,
                 33'h0_0000_2024, 33'h0_0000_2090, 33'h1_0000_2067);
    dir[2] = mkv("bad_parity", 64'h035, 9, 1'b0, 1, 33'h1_0000_2135, '0, '0);
    dir[3] = mkv("seven_bits", 64'h26, 7, 1'b0, 1, 33'h1_0000_1C26, '0, '0);
    dir[4] = mkv("cerr_3bits", 64'h5, 3, 1'b1, 1, 33'h1_0000_0E05, '0, '0);
    dir[5] = mkv("after_cerr", 64'h1A5, 9, 1'b0, 1, 33'h1_0000_20A5, '0, '0);
    dir[6] = mkv("empty", 64'h0, 0, 1'b0, 0, '0, '0, '0);
    dir[7] = mkv("cerr_pending", 64'h135, 9, 1'b1, 1, 33'h1_0000_2235, '0, '0);
    dir[8] = mkv("byte_partial", 64'h135 | (64'h3 << 9), 11, 1'b0, 2,
                 33'h0_0000_2035, 33'h1_0000_0803, '0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_m_tstrb", 64'(m_tstrb), 64'd0);
    check("rst_frame_count", 64'(fcnt), 64'd0);
    check("rst_overflow", 64'(ovf), 64'd0);
    aresetn = 1'b1;
    #1;
    check("s_tready_after_reset", 64'(s_tready), 64'd1);
    rdy_mode = 1;
    idle(4);

    for (int i = 0; i < 9; i++) run_vec(dir[i]);

    // Active-active first pair is not a valid SOF: no output.
    send_half(1'b1);
    send_half(1'b1);
    idle(6);
    drain();
    check("false_sof_nwords", 64'(got.size()), 64'd0);
    got.delete();
    run_vec(dir[0]);

    // Stalled output across a three-byte frame.
    rdy_mode = 2;
    idle(2);
    send_frame(dir[1]);
    idle(6);
    check("stall_tvalid", 64'(m_tvalid), 64'd1);
    check("stall_held_data", 64'(m_tdata), 64'h2024);
    check("stall_held_tlast", 64'(m_tlast), 64'd0);
    check("stall_tstrb", 64'(m_tstrb), 64'hF);
    check("stall_overflow", 64'(ovf), 64'd1);
    check("stall_frame_count", 64'(fcnt), 64'(16'(exp_fcnt + 1)));
    check("stall_accepted", 64'(got.size()), 64'd0);

    // Reset in the middle of a frame.
    send_half(1'b1);
    send_half(1'b0);
    send_half(1'b1);
    send_half(1'b0);
    send_half(1'b0);
    send_half(1'b1);
    #2 aresetn = 1'b0;
    #1;
    check("midrst_s_tready", 64'(s_tready), 64'd0);
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_m_tdata", 64'(m_tdata), 64'd0);
    check("midrst_m_tlast", 64'(m_tlast), 64'd0);
    check("midrst_m_tstrb", 64'(m_tstrb), 64'd0);
    check("midrst_frame_count", 64'(fcnt), 64'd0);
    check("midrst_overflow", 64'(ovf), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    aresetn  = 1'b1;
    exp_fcnt = 0;
    got.delete();
    rdy_mode = 1;
    idle(4);
    run_vec(dir[1]);

    for (int k = 0; k < 40; k++) begin
      rand_frame(k, v);
      run_vec(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/picc_rx_decoder.md
Name: picc_rx_decoder

Overview:
- Downstream consumer of the PICC-to-PCD AXI-Stream sample source: takes signed load-modulated amplitude samples and recovers the transmitted frame.
- Integrates sample magnitude per half-bit, slices each half-bit against a threshold, and Manchester-decodes the result with SOF/EOF detection.
- Assembles LSB-first bytes, checks odd parity, and emits one AXI-Stream word per byte, with tlast on the final byte of the frame.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, input sample width (signed).
- C_M00_AXIS_TDATA_WIDTH, 32, output word width.
- HALF_BIT_SAMPLES, 64, samples per Manchester half-bit (power of 2, ≥4).
- SAMPLE_THRESHOLD, 32'd1000, per-sample magnitude that starts a frame (SOF detect).
- ENERGY_THRESHOLD, 40'd32000, half-bit magnitude sum above which the half-bit is "active".

Ports:
- s00_axis_aclk  in  1  sole clock.
- s00_axis_aresetn  in  1  async active-low reset.
- s00_axis_tvalid  in  1  input sample valid.
- s00_axis_tready  out  1  input ready.
- s00_axis_tdata  in  32  signed amplitude sample.
- s00_axis_tlast  in  1  ignored.
- s00_axis_tstrb  in  4  ignored.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tvalid  out  1  output word valid.
- m00_axis_tlast  out  1  last byte of frame.
- m00_axis_tdata  out  32  output word: [7:0] data, [8] parity_err, [9] coding_err, [13:10] valid bit count (1..8), [31:14] zero.
- m00_axis_tstrb  out  4  always 4'hF while tvalid is high.
- frame_count_out  out  16  completed frames; wraps modulo 2^16.
- overflow_out  out  1  sticky: a byte was dropped because the output was occupied.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; accumulators, bit and byte counters cleared. s00_axis_tready = 1 whenever aresetn is high; samples are consumed every accepted beat.
- Magnitude: |x|, saturating −2^31 to 2^31−1. Accumulator width is 32 + log2(HALF_BIT_SAMPLES), saturating.
- IDLE: first accepted sample with magnitude > SAMPLE_THRESHOLD moves the block to SOF. That sample is sample 0 of half-bit window 0 and is included in its sum.
- Half-bit level: after HALF_BIT_SAMPLES accepted samples, the level is 1 if sum > ENERGY_THRESHOLD, else 0. The accumulator then clears. Windows advance only on accepted beats.
- Bit decode on each half-bit pair (first, second): (1,0)=1; (0,1)=0; (0,0)=EOF; (1,1)=coding error.
- SOF: the first pair must be (1,0); any other pair returns the block to IDLE with no output.
- DATA: bits shift in LSB first. After 8 data bits the 9th is parity. parity_err is set if the ones-count of the 9 bits is even. The byte moves to a pending register, and bit count resets.
- Pending byte: emitted (tlast=0) when the next decoded bit is a data bit, or emitted with tlast=1 when the next pair is EOF.
- EOF with 1–7 partial bits: partial byte is emitted right-aligned with tlast=1 and count = bits; any full pending byte goes out first with tlast=0.
- EOF with no pending and no partial bits: no output.
- frame_count_out increments on the cycle tlast is accepted.
- Coding error (1,1): the current partial/pending byte is emitted with coding_err=1 and tlast=1; the block returns to IDLE.
- Output register: holds tvalid/tdata/tlast until tvalid&&tready.
- Output register occupied when a new word is ready: the new word is dropped and overflow_out is set (sticky until reset). If the dropped word had tlast, frame_count_out still increments.
- Latency: an emitted word appears in the output register 1 cycle after the half-bit pair that releases it. Release happens on the last sample of the following bit, or of EOF.
- Reset mid-frame: immediate abort; any partial data is discarded.

Test Plan:
- HALF_BIT_SAMPLES=4, thresholds 1000/3000. Drive amplitude ±2000 on active half-bits, 0 on inactive. SOF, then byte 8'h35 LSB-first with parity 1, then EOF → one word tdata=0x00002035, tlast=1; frame_count_out=1.
- Frame with bytes 0x24,0x90,0x67 → words 0x2024, 0x2090, 0x2067 (parity set correctly); only the last word has tlast=1.
- Byte 0x35 with parity bit 0 → tdata=0x00002135 (parity_err=1), tlast=1.
- 7-bit frame 0x26 then EOF → tdata=0x00001C26 (count=7), tlast=1.
- Insert a (1,1) pair after 3 bits of 0b101 → tdata=0x00000E05 (coding_err=1, count=3), tlast=1; next SOF decodes normally.
- Hold m00_axis_tready=0 across a 3-byte frame → first word held stable, overflow_out=1, second/third bytes dropped; assert aresetn=0 mid-frame → all outputs 0 immediately.
